// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the sequential multi-precision adder/subtractor:
// slice width, controller state encoding and slice-index sizing.
package mp_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-bit counter is kept even for the smallest legal WORDS.
  function automatic int idx_width(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/mp_add_seq_cla16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups whose
// group carries are resolved by a second lookahead level.
module CLA16 (
  output logic [15:0] S,
  output logic        Co,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        Cin
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [3:0]  w_gg;
  logic [3:0]  w_pg;
  logic [3:0]  w_gc;

  assign w_g = X & Y;
  assign w_p = X ^ Y;

  always_comb begin
    w_gg = '0;
    w_pg = '0;
    for (int i = 0; i < 4; i++) begin
      w_gg[i] = w_g[4*i+3]
              | (w_p[4*i+3] & w_g[4*i+2])
              | (w_p[4*i+3] & w_p[4*i+2] & w_g[4*i+1])
              | ((&w_p[4*i+1 +: 3]) & w_g[4*i]);
      w_pg[i] = &w_p[4*i +: 4];
    end
  end

  assign w_gc[0] = Cin;
  assign w_gc[1] = w_gg[0] | (w_pg[0] & Cin);
  assign w_gc[2] = w_gg[1] | (w_pg[1] & w_gg[0]) | (w_pg[1] & w_pg[0] & Cin);
  assign w_gc[3] = w_gg[2] | (w_pg[2] & w_gg[1]) | (w_pg[2] & w_pg[1] & w_gg[0])
                 | (w_pg[2] & w_pg[1] & w_pg[0] & Cin);
  assign Co      = w_gg[3] | (w_pg[3] & w_gg[2]) | (w_pg[3] & w_pg[2] & w_gg[1])
                 | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
                 | (&w_pg & Cin);

  // Within a group the carry is derived from that group's lookahead carry-in.
  always_comb begin : sum_bits
    logic c;
    c = 1'b0;
    S = '0;
    for (int i = 0; i < 4; i++) begin
      c = w_gc[i];
      for (int j = 0; j < 4; j++) begin
        S[4*i+j] = w_p[4*i+j] ^ c;
        c        = w_g[4*i+j] | (w_p[4*i+j] & c);
      end
    end
  end

endmodule

// File: rtl/mp_add_seq.sv
// Sequential multi-precision adder/subtractor: pushes a WORDS x 16-bit
// operand pair through one shared CLA16, one slice per cycle, LSB first.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [SLICE_W*WORDS-1:0] X,
  input  logic [SLICE_W*WORDS-1:0] Y,
  input  logic                   Cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SLICE_W*WORDS-1:0] S,
  output logic                   Co,
  output logic                   Ovf
);

  localparam int N  = SLICE_W * WORDS;
  localparam int KW = idx_width(WORDS);
  localparam logic [KW-1:0] LAST_IDX = KW'(WORDS - 1);

  state_t          r_state;
  state_t          w_next_state;
  logic [N-1:0]    r_x;
  logic [N-1:0]    r_y;
  logic [N-1:0]    r_s;
  logic            r_carry;
  logic [KW-1:0]   r_idx;
  logic            r_co;
  logic            r_ovf;

  logic [SLICE_W-1:0] w_xs;
  logic [SLICE_W-1:0] w_ys;
  logic [SLICE_W-1:0] w_sum;
  logic               w_co;
  logic               w_last;

  assign w_xs   = r_x[int'(r_idx)*SLICE_W +: SLICE_W];
  assign w_ys   = r_y[int'(r_idx)*SLICE_W +: SLICE_W];
  assign w_last = (r_idx == LAST_IDX);

  CLA16 u_cla (
    .S   (w_sum),
    .Co  (w_co),
    .X   (w_xs),
    .Y   (w_ys),
    .Cin (r_carry)
  );

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = RUN;
      end
      RUN: begin
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Subtraction is folded into the stored operand: Y is inverted at accept
  // and the carry seeded with 1, so RUN never needs to know the op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= X;
            r_y     <= op_sub ? ~Y : Y;
            r_carry <= op_sub ? 1'b1 : Cin;
            r_idx   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        RUN: begin
          r_s[int'(r_idx)*SLICE_W +: SLICE_W] <= w_sum;
          r_carry <= w_co;
          if (w_last) begin
            r_idx <= '0;
            r_co  <= w_co;
            r_ovf <= (w_xs[SLICE_W-1] ~^ w_ys[SLICE_W-1])
                   & (w_xs[SLICE_W-1] ^ w_sum[SLICE_W-1]);
          end else begin
            r_idx <= r_idx + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign S   = r_s;
  assign Co  = r_co;
  assign Ovf = r_ovf;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed self-checking bench for mp_add_seq with WORDS=4 (64-bit operands):
// add/sub corner cases, latency, backpressure and mid-operation reset.
module tb_mp_add_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [63:0] X;
  logic [63:0] Y;
  logic        Cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] S;
  logic        Co;
  logic        Ovf;

  int errors = 0;
  int checks = 0;

  mp_add_seq #(.WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .X         (X),
    .Y         (Y),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Co        (Co),
    .Ovf       (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] expS,
                             input logic expCo, input logic expOvf);
    checkVal({tag, ".S"},   S,            expS);
    checkVal({tag, ".Co"},  {63'd0, Co},  {63'd0, expCo});
    checkVal({tag, ".Ovf"}, {63'd0, Ovf}, {63'd0, expOvf});
  endtask

  // Presents one request for the accept edge, then scrambles the operand pins.
  task automatic applyStimulus(input string tag, input logic sub, input logic [63:0] a,
                               input logic [63:0] b, input logic ci);
    checkVal({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    op_sub   = sub;
    X        = a;
    Y        = b;
    Cin      = ci;
    tick();
    in_valid = 1'b0;
    X        = 64'hDEAD_BEEF_CAFE_F00D;
    Y        = 64'h0BAD_F00D_1234_5678;
    op_sub   = ~sub;
    Cin      = ~ci;
  endtask

  task automatic waitResult(input string tag, input int expLat);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checkVal({tag, ".latency"}, 64'(lat), 64'(expLat));
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkVal({tag, ".rel_in_ready"},  {63'd0, in_ready},  64'd1);
    checkVal({tag, ".rel_out_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    X         = '0;
    Y         = '0;
    Cin       = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkVal("reset.in_ready",  {63'd0, in_ready},  64'd1);
    checkVal("reset.out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset", 64'd0, 1'b0, 1'b0);

    applyStimulus("add_ffff", 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    waitResult("add_ffff", 4);
    checkOutput("add_ffff", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    releaseResult("add_ffff");

    applyStimulus("add_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    waitResult("add_wrap", 4);
    checkOutput("add_wrap", 64'h0, 1'b1, 1'b0);
    releaseResult("add_wrap");

    applyStimulus("add_cin", 1'b0, 64'h0, 64'h0, 1'b1);
    waitResult("add_cin", 4);
    checkOutput("add_cin", 64'h1, 1'b0, 1'b0);
    releaseResult("add_cin");

    applyStimulus("add_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    waitResult("add_ovf", 4);
    checkOutput("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    releaseResult("add_ovf");

    applyStimulus("add_mix", 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    waitResult("add_mix", 4);
    checkOutput("add_mix", 64'h2222_2222_2222_2212, 1'b0, 1'b0);
    releaseResult("add_mix");

    applyStimulus("sub_5_7", 1'b1, 64'd5, 64'd7, 1'b1);
    waitResult("sub_5_7", 4);
    checkOutput("sub_5_7", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    releaseResult("sub_5_7");

    applyStimulus("sub_7_5", 1'b1, 64'd7, 64'd5, 1'b0);
    waitResult("sub_7_5", 4);
    checkOutput("sub_7_5", 64'h2, 1'b1, 1'b0);
    releaseResult("sub_7_5");

    applyStimulus("sub_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0);
    waitResult("sub_ovf", 4);
    checkOutput("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    releaseResult("sub_ovf");

    // Backpressure: result held while a competing request sits on the inputs.
    applyStimulus("bp", 1'b0, 64'h0001_0000_0000_0000, 64'hFFFF_0000_0000_0000, 1'b0);
    waitResult("bp", 4);
    checkOutput("bp", 64'h0, 1'b1, 1'b0);
    in_valid = 1'b1;
    op_sub   = 1'b0;
    X        = 64'd3;
    Y        = 64'd4;
    Cin      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_hold", 64'h0, 1'b1, 1'b0);
      checkVal("bp_hold.out_valid", {63'd0, out_valid}, 64'd1);
      checkVal("bp_hold.in_ready",  {63'd0, in_ready},  64'd0);
    end
    releaseResult("bp");
    tick();
    in_valid = 1'b0;
    X        = 64'hFFFF_FFFF_FFFF_FFFF;
    Y        = 64'hFFFF_FFFF_FFFF_FFFF;
    checkVal("bp_next.in_ready", {63'd0, in_ready}, 64'd0);
    waitResult("bp_next", 4);
    checkOutput("bp_next", 64'd7, 1'b0, 1'b0);
    releaseResult("bp_next");

    // Reset during the second RUN cycle must discard the operation.
    applyStimulus("rst_mid", 1'b0, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkVal("rst_mid.in_ready",  {63'd0, in_ready},  64'd1);
    checkVal("rst_mid.out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_mid", 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkVal("rst_mid.idle_out_valid", {63'd0, out_valid}, 64'd0);
    end

    applyStimulus("post_rst", 1'b0, 64'h1, 64'h1, 1'b0);
    waitResult("post_rst", 4);
    checkOutput("post_rst", 64'h2, 1'b0, 1'b0);
    releaseResult("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
